// File: rtl/cdc_sync_event_capture.sv
// -----------------------------------------------------------------------------
// cdc_sync_event_capture
//
// Destination-domain stage that sits directly after a 2-flop synchronizer.
// It filters the synchronized level, turns qualified level changes into events,
// and accumulates those events in a saturating pending counter. The consumer
// drains the counter over a valid/ready handshake. A sticky flag records any
// event lost to saturation. Everything runs in clk_b; no crossing happens here.
//
// Parameters
//   EDGE_MODE      0 = rising, 1 = falling, 2 = both edges count as events
//   STABLE_CYCLES  consecutive samples a new level must hold before acceptance
//   CNT_W          pending counter width (max pending = 2**CNT_W-1)
//
// Ports
//   clk_b          in   destination clock, all logic on posedge
//   rst_b_n        in   synchronous active-low reset
//   sync_in        in   synchronized level from the 2nd synchronizer flop
//   level_out      out  filtered level
//   evt_valid      out  pending count is non-zero
//   evt_count      out  events pending since the last handshake
//   evt_ready      in   consumer takes evt_count when evt_valid && evt_ready
//   evt_overflow   out  sticky: an event was lost because the counter was full
//   clr_overflow   in   clears evt_overflow (a simultaneous loss wins)
// -----------------------------------------------------------------------------
module cdc_sync_event_capture #(
    parameter int EDGE_MODE     = 0,
    parameter int STABLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic             clk_b,
    input  logic             rst_b_n,
    input  logic             sync_in,
    output logic             level_out,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_count,
    input  logic             evt_ready,
    output logic             evt_overflow,
    input  logic             clr_overflow
);

    if (STABLE_CYCLES < 1 || EDGE_MODE < 0 || EDGE_MODE > 2 || CNT_W < 1) begin : g_bad_param
        $error("cdc_sync_event_capture: illegal STABLE_CYCLES/EDGE_MODE/CNT_W");
    end

    // Qualification counter only ever needs to hold 0..STABLE_CYCLES-1.
    localparam int QW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0]    QUAL_LAST = QW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_QUAL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             level_q, level_d;
    logic [QW-1:0]    qual_q, qual_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             edge_hit;
    logic             evt_hit;
    logic             handshake;

    // Level filter: next-state, next-level and edge strobe.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        qual_d   = qual_q;
        edge_hit = 1'b0;
        case (state_q)
            ST_INIT: begin
                // Adopt whatever level is present; a high input at reset
                // release is the starting level, not an edge.
                level_d = sync_in;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (sync_in != level_q) begin
                    if (STABLE_CYCLES == 1) begin
                        level_d  = sync_in;
                        edge_hit = 1'b1;
                    end else begin
                        qual_d  = QW'(1);
                        state_d = ST_QUAL;
                    end
                end
            end
            ST_QUAL: begin
                if (sync_in == level_q) begin
                    // Input fell back before holding long enough: drop it.
                    qual_d  = '0;
                    state_d = ST_IDLE;
                end else if (qual_q == QUAL_LAST) begin
                    level_d  = sync_in;
                    edge_hit = 1'b1;
                    qual_d   = '0;
                    state_d  = ST_IDLE;
                end else begin
                    qual_d = qual_q + QW'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                qual_d  = '0;
            end
        endcase
    end

    // Edge direction is judged against the newly accepted level.
    assign evt_hit = (EDGE_MODE == 2) ? edge_hit :
                     (EDGE_MODE == 1) ? (edge_hit & ~level_d) :
                                        (edge_hit &  level_d);

    assign handshake = evt_ready & valid_q;

    // Pending counter and sticky overflow.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (clr_overflow) begin
            ovf_d = 1'b0;
        end
        if (handshake) begin
            // An event arriving with the handshake starts the next batch,
            // so it is neither lost nor folded into the accepted value.
            pend_d = evt_hit ? CNT_W'(1) : '0;
        end else if (evt_hit) begin
            if (pend_q != CNT_MAX) begin
                pend_d = pend_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        valid_d = (pend_d != '0);
    end

    always_ff @(posedge clk_b) begin
        if (!rst_b_n) begin
            state_q <= ST_INIT;
            level_q <= 1'b0;
            qual_q  <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            qual_q  <= qual_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level_out    = level_q;
    assign evt_valid    = valid_q;
    assign evt_count    = pend_q;
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_cdc_sync_event_capture.sv
// -----------------------------------------------------------------------------
// Directed testbench for cdc_sync_event_capture. Three instances share one
// clock: A uses defaults, B filters with STABLE_CYCLES=3, C counts both edges
// in a 2-bit counter so saturation is easy to reach.
// -----------------------------------------------------------------------------
module tb_cdc_sync_event_capture;

    logic clk_b = 1'b0;
    always #5 clk_b = ~clk_b;

    int errors = 0;
    int checks = 0;

    // Instance A: defaults
    logic       a_rst_n = 1'b0, a_sync = 1'b0, a_ready = 1'b0, a_clr = 1'b0;
    logic       a_level, a_valid, a_ovf;
    logic [3:0] a_count;

    // Instance B: STABLE_CYCLES = 3
    logic       b_rst_n = 1'b0, b_sync = 1'b0, b_ready = 1'b0, b_clr = 1'b0;
    logic       b_level, b_valid, b_ovf;
    logic [3:0] b_count;

    // Instance C: EDGE_MODE = 2, CNT_W = 2
    logic       c_rst_n = 1'b0, c_sync = 1'b0, c_ready = 1'b0, c_clr = 1'b0;
    logic       c_level, c_valid, c_ovf;
    logic [1:0] c_count;

    cdc_sync_event_capture u_a (
        .clk_b(clk_b), .rst_b_n(a_rst_n), .sync_in(a_sync), .level_out(a_level),
        .evt_valid(a_valid), .evt_count(a_count), .evt_ready(a_ready),
        .evt_overflow(a_ovf), .clr_overflow(a_clr));

    cdc_sync_event_capture #(.EDGE_MODE(0), .STABLE_CYCLES(3), .CNT_W(4)) u_b (
        .clk_b(clk_b), .rst_b_n(b_rst_n), .sync_in(b_sync), .level_out(b_level),
        .evt_valid(b_valid), .evt_count(b_count), .evt_ready(b_ready),
        .evt_overflow(b_ovf), .clr_overflow(b_clr));

    cdc_sync_event_capture #(.EDGE_MODE(2), .STABLE_CYCLES(1), .CNT_W(2)) u_c (
        .clk_b(clk_b), .rst_b_n(c_rst_n), .sync_in(c_sync), .level_out(c_level),
        .evt_valid(c_valid), .evt_count(c_count), .evt_ready(c_ready),
        .evt_overflow(c_ovf), .clr_overflow(c_clr));

    // Inputs set before tick() are sampled by its posedge; outputs are read 1ns later.
    task automatic tick();
        @(posedge clk_b);
        #1;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; a_sync = 1'b1;
        tick();
        checks++;
        if ({a_level, a_valid, a_count, a_ovf} !== 7'b0) begin
            $display("FAIL reset_state: got %b expected 0000000", {a_level, a_valid, a_count, a_ovf});
            errors++;
        end
        a_rst_n = 1'b1;
        tick();
        checks++;
        if (a_level !== 1'b1) begin
            $display("FAIL init_level_high: got %b expected 1", a_level);
            errors++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (a_valid !== 1'b0) begin
                $display("FAIL init_no_event cycle %0d: got %b expected 0", i, a_valid);
                errors++;
            end
        end
    endtask

    task automatic test_rise_handshake();
        a_rst_n = 1'b0; a_sync = 1'b0;
        tick();
        a_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (a_valid !== 1'b0) begin
                $display("FAIL quiet_before_rise: got %b expected 0", a_valid);
                errors++;
            end
        end
        a_sync = 1'b1;
        tick();
        checks++;
        if ({a_level, a_valid, a_count} !== {1'b1, 1'b1, 4'd1}) begin
            $display("FAIL rise_event: got lvl=%b vld=%b cnt=%0d expected 1 1 1", a_level, a_valid, a_count);
            errors++;
        end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        checks++;
        if ({a_valid, a_count} !== {1'b0, 4'd0}) begin
            $display("FAIL drain: got vld=%b cnt=%0d expected 0 0", a_valid, a_count);
            errors++;
        end
        tick();
        checks++;
        if (a_count !== 4'd0) begin
            $display("FAIL ready_idle_no_effect: got %0d expected 0", a_count);
            errors++;
        end
    endtask

    task automatic test_glitch_filter();
        b_rst_n = 1'b0; b_sync = 1'b0;
        tick();
        b_rst_n = 1'b1;
        tick();
        b_sync = 1'b1;
        tick();
        tick();
        b_sync = 1'b0;
        tick();
        tick();
        checks++;
        if ({b_level, b_valid} !== 2'b00) begin
            $display("FAIL glitch_dropped: got lvl=%b vld=%b expected 0 0", b_level, b_valid);
            errors++;
        end
        b_sync = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if ({b_level, b_valid} !== 2'b00) begin
                $display("FAIL qual_pending sample %0d: got lvl=%b vld=%b expected 0 0", i, b_level, b_valid);
                errors++;
            end
        end
        tick();
        checks++;
        if ({b_level, b_valid, b_count} !== {1'b1, 1'b1, 4'd1}) begin
            $display("FAIL qualified_rise: got lvl=%b vld=%b cnt=%0d expected 1 1 1", b_level, b_valid, b_count);
            errors++;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [6];
        logic       exp_ovf [6];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        c_rst_n = 1'b0; c_sync = 1'b0;
        tick();
        c_rst_n = 1'b1;
        tick();
        for (int t = 0; t < 6; t++) begin
            c_sync = ~c_sync;
            if (t == 5) c_clr = 1'b1;
            tick();
            checks++;
            if ({c_count, c_ovf} !== {exp_cnt[t], exp_ovf[t]}) begin
                $display("FAIL toggle %0d: got cnt=%0d ovf=%b expected %0d %b", t + 1, c_count, c_ovf, exp_cnt[t], exp_ovf[t]);
                errors++;
            end
            if (t < 5) tick();
        end
        tick();
        c_clr = 1'b0;
        checks++;
        if ({c_count, c_ovf} !== {2'd3, 1'b0}) begin
            $display("FAIL clr_overflow: got cnt=%0d ovf=%b expected 3 0", c_count, c_ovf);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        checks++;
        if ({c_valid, c_count} !== {1'b0, 2'd0}) begin
            $display("FAIL drain_c: got vld=%b cnt=%0d expected 0 0", c_valid, c_count);
            errors++;
        end
        c_sync = ~c_sync;
        tick();
        tick();
        c_sync = ~c_sync;
        tick();
        tick();
        checks++;
        if ({c_valid, c_count} !== {1'b1, 2'd2}) begin
            $display("FAIL presented_value: got vld=%b cnt=%0d expected 1 2", c_valid, c_count);
            errors++;
        end
        c_sync = ~c_sync;
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        checks++;
        if ({c_valid, c_count, c_ovf} !== {1'b1, 2'd1, 1'b0}) begin
            $display("FAIL coincident_event: got vld=%b cnt=%0d ovf=%b expected 1 1 0", c_valid, c_count, c_ovf);
            errors++;
        end
    endtask

    task automatic test_reset_mid_qual();
        // B enters with level=1, count=1, sync=1. Fall (not counted), then another rise.
        b_sync = 1'b0;
        repeat (3) tick();
        b_sync = 1'b1;
        repeat (3) tick();
        b_sync = 1'b0;
        tick();
        checks++;
        if ({b_level, b_valid, b_count} !== {1'b1, 1'b1, 4'd2}) begin
            $display("FAIL pre_reset_state: got lvl=%b vld=%b cnt=%0d expected 1 1 2", b_level, b_valid, b_count);
            errors++;
        end
        b_rst_n = 1'b0; b_sync = 1'b1;
        tick();
        checks++;
        if ({b_level, b_valid, b_count, b_ovf} !== 7'b0) begin
            $display("FAIL mid_qual_reset: got %b expected 0000000", {b_level, b_valid, b_count, b_ovf});
            errors++;
        end
        b_rst_n = 1'b1;
        tick();
        checks++;
        if ({b_level, b_valid} !== 2'b10) begin
            $display("FAIL resync_level: got lvl=%b vld=%b expected 1 0", b_level, b_valid);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (b_valid !== 1'b0) begin
                $display("FAIL no_spurious cycle %0d: got %b expected 0", i, b_valid);
                errors++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rise_handshake();
        test_glitch_filter();
        test_saturation();
        test_back_to_back();
        test_reset_mid_qual();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
